// File: rtl/serial_twos_comp_unit.sv
// Bit-serial two's-complement unit: LSB-first negate/pass-through with a parallel word output.
// Optional negation-overflow flag is built only when SERIAL_TWOS_OVF_EN is defined.
module serial_twos_comp_unit #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             flush,
  input  logic             mode,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             y_bit,
  output logic             y_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_seen_one;
  logic             r_mode_q;
  logic [WIDTH-2:0] r_shift_q;
  logic [WIDTH-1:0] r_out_word;
  logic             r_out_valid;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_bit_cnt_nxt;
  logic             w_seen_one_nxt;
  logic             w_mode_q_nxt;
  logic [WIDTH-2:0] w_shift_q_nxt;
  logic [WIDTH-1:0] w_out_word_nxt;
  logic             w_out_valid_nxt;

  logic             w_first;
  logic             w_last;
  logic             w_eff_mode;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_y_bit;
  logic [WIDTH-1:0] w_shift_full;

  // The first bit of a word uses the live mode so the result is available with zero latency.
  assign w_first      = (r_bit_cnt == '0);
  assign w_last       = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_eff_mode   = w_first ? mode : r_mode_q;
  assign w_in_ready   = (r_state == COLLECT) & ~flush;
  assign w_accept     = in_valid & w_in_ready;
  assign w_y_bit      = in_bit ^ (w_eff_mode & r_seen_one);
  assign w_shift_full = {w_y_bit, r_shift_q};

  assign in_ready  = w_in_ready;
  assign y_valid   = w_accept;
  assign y_bit     = w_y_bit;
  assign out_word  = r_out_word;
  assign out_valid = r_out_valid;

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      r_state     <= COLLECT;
      r_bit_cnt   <= '0;
      r_seen_one  <= 1'b0;
      r_mode_q    <= 1'b0;
      r_shift_q   <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_seen_one  <= w_seen_one_nxt;
      r_mode_q    <= w_mode_q_nxt;
      r_shift_q   <= w_shift_q_nxt;
      r_out_word  <= w_out_word_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_seen_one_nxt  = r_seen_one;
    w_mode_q_nxt    = r_mode_q;
    w_shift_q_nxt   = r_shift_q;
    w_out_word_nxt  = r_out_word;
    w_out_valid_nxt = r_out_valid;

    if (r_state == COLLECT) begin
      if (w_accept) begin
        if (w_first) begin
          w_mode_q_nxt = mode;
        end
        w_seen_one_nxt = r_seen_one | in_bit;
        w_shift_q_nxt  = w_shift_full[WIDTH-1:1];
        w_bit_cnt_nxt  = r_bit_cnt + CW'(1);
        if (w_last) begin
          w_out_word_nxt  = w_shift_full;
          w_out_valid_nxt = 1'b1;
          w_bit_cnt_nxt   = '0;
          w_seen_one_nxt  = 1'b0;
          w_state_nxt     = HOLD;
        end
      end
    end else begin
      if (out_ready) begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = COLLECT;
      end
    end

    // Flush only abandons the partial word; a held output word is untouched.
    if (flush) begin
      w_bit_cnt_nxt  = '0;
      w_seen_one_nxt = 1'b0;
      w_shift_q_nxt  = '0;
    end
  end

`ifdef SERIAL_TWOS_OVF_EN
  logic r_ovf;

  // Overflow only when the word is exactly 100..0 and negated: no 1 seen before the MSB.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_last) begin
      r_ovf <= ~r_seen_one & in_bit & w_eff_mode;
    end else if ((r_state == HOLD) && out_ready) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_twos_comp_unit.md
Name: serial_twos_comp_unit

Overview:
Parametrised bit-serial two's-complement unit. It generalises the single-bit serial complementer to a framed WIDTH-bit word stream. Each word can be negated or passed through, selected per word.
- Input arrives LSB-first with a valid/ready handshake.
- Each result bit is produced serially in the same cycle as its input bit.
- The completed word is also assembled and presented in parallel behind a valid/ready handshake.
- It sits between serial arithmetic datapaths and word-oriented consumers.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.

Ports:
t_clk  input  1  clock; all state updates on rising edge.
r  input  1  reset; asynchronous, active-high.
flush  input  1  synchronous abort of the partial word; higher priority than data.
mode  input  1  0 = pass-through, 1 = negate; sampled on the first bit of each word.
in_valid  input  1  in_bit is valid this cycle.
in_bit  input  1  serial data bit, LSB first.
in_ready  output  1  unit accepts a bit this cycle.
y_bit  output  1  serial result bit; combinational from in_bit and state.
y_valid  output  1  y_bit valid; equals in_valid & in_ready.
out_word  output  WIDTH  assembled result word.
out_valid  output  1  out_word holds a complete word.
out_ready  input  1  consumer accepts out_word.
ovf  output  1  negation overflow flag for the held word (see Optional Feature).

Behaviour:
- Accept event: in_valid & in_ready at a rising edge.
- State machine has two states, COLLECT and HOLD.
- Reset (r=1, async):
  - state=COLLECT, bit_cnt=0, seen_one=0, mode_q=0.
  - shift_q=0, out_word=0, out_valid=0, ovf=0, in_ready=1.
- COLLECT:
  - in_ready=1.
  - On accept with bit_cnt==0: mode_q <= mode. The effective mode for this bit is the live `mode` input.
  - For bits after the first, the effective mode is mode_q.
  - y_bit = in_bit XOR (eff_mode & seen_one). This gives zero-latency serial output.
  - On accept: seen_one <= seen_one | in_bit; shift_q <= {y_bit, shift_q[WIDTH-1:1]}; bit_cnt++.
  - On accept with bit_cnt==WIDTH-1:
    - out_word <= {y_bit, shift_q[WIDTH-1:1]}; out_valid <= 1.
    - bit_cnt <= 0; seen_one <= 0; state <= HOLD.
- HOLD:
  - in_ready=0; y_valid=0.
  - out_word and out_valid are stable until out_ready=1.
  - When out_ready=1: out_valid <= 0, state <= COLLECT. One bubble cycle precedes the next accept.
- flush=1 (synchronous, either state):
  - bit_cnt <= 0, seen_one <= 0, shift_q <= 0.
  - A bit presented in the same cycle is discarded: in_ready=0 while flush=1.
  - A held word (out_valid=1) is not discarded; flush leaves out_word, out_valid and ovf unchanged.
- Mode changes mid-word are ignored until the next word's first bit.
- bit_cnt width is clog2(WIDTH); it wraps to 0 only at word end or on flush/reset.
- Reset asserted mid-word or in HOLD drops all state immediately. The next accepted bit is bit 0 of a fresh word.
- Arithmetic is modulo 2^WIDTH. Negating 0 yields 0. Negating the most-negative value yields itself.

Optional Feature:
Macro: SERIAL_TWOS_OVF_EN.
- Defined:
  - An ovf tracker monitors the word: all bits 0..WIDTH-2 are 0, bit WIDTH-1 is 1, and effective mode=1.
  - When the word completes, the tracker result is loaded into ovf together with out_valid.
  - ovf clears with out_valid on handshake, and on reset.
  - Pass-through words always give ovf=0.
- Not defined: ovf is tied 0 and no tracker logic is built. The port list is unchanged.

Test Plan:
- WIDTH=8, mode=1, serial bits of 0x05 (1,0,1,0,0,0,0,0) -> y_bit 1,1,0,1,1,1,1,1; out_word=0xFB, out_valid=1 one edge after the 8th bit; ovf=0.
- mode=0, input 0xA6 -> y_bit mirrors in_bit each cycle; out_word=0xA6. Then mode=1, input 0x00 -> out_word=0x00; seen_one never set.
- mode=1, input 0x80 -> out_word=0x80. With SERIAL_TWOS_OVF_EN: ovf=1. Without the macro: ovf=0.
- Complete a word with out_ready=0 for 3 cycles -> in_ready=0, y_valid=0, out_word held. out_ready=1 -> out_valid falls next edge; in_ready=1 the following cycle.
- Toggle mode 1->0 after bit 2 of 0x05 -> whole word still negated, out_word=0xFB.
- Assert r asynchronously after 3 bits -> outputs at reset values immediately. Then feed 8 bits of 0x01 with mode=1 -> out_word=0xFF.
- Pulse flush after 5 bits -> bit_cnt=0. Next 8 bits of 0x03 with mode=1 -> out_word=0xFD.
